regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, number of architectural registers.
REQ-002 SHALL have parameter W, default 32, register data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports a_valid/a_ready, input/output, 1 each, ALU writeback handshake.
REQ-006 SHALL have ports a_addr/a_data, input, $clog2(N)/W, ALU destination register and value.
REQ-007 SHALL have ports b_valid/b_ready, input/output, 1 each, load-unit writeback handshake.
REQ-008 SHALL have ports b_addr/b_data, input, $clog2(N)/W, load destination register and value.
REQ-009 SHALL have ports wen/waddr/wdata, output, 1/$clog2(N)/W, the register-file write port, all registered.
REQ-010 SHALL have port conflict_cnt, output, 16, saturating count of contested cycles.

Function
REQ-011 SHALL hold one one-entry buffer per requester (full flag, addr, data).
REQ-012 SHALL accept a request at an edge when x_valid and x_ready are both high, loading that requester's buffer.
REQ-013 SHALL drive x_ready = !full_x | grant_x (combinational), so a drained buffer reloads in the same cycle.
REQ-014 SHALL grant exactly one full buffer per cycle; with a single full buffer, that buffer SHALL be granted.
REQ-015 SHALL, at the edge following a grant, load waddr/wdata from the granted buffer and clear its full flag, unless it reloads at that edge.
REQ-016 SHALL assert wen for exactly one cycle per granted entry whose addr != 0.
REQ-017 SHALL drop entries with addr == 0: they are granted and cleared, wen stays 0, and waddr/wdata still update.
REQ-018 SHALL deassert wen in any cycle following no grant; waddr/wdata then hold their previous values.
REQ-019 SHALL have latency: accept at edge k, write visible after edge k+1 when uncontested, for a sustained throughput of 1 write/cycle.
REQ-020 SHALL NOT merge two entries with the same address; both SHALL be written, in grant order.
REQ-021 SHALL increment conflict_cnt at each edge where both buffers are full, saturating at 16'hFFFF.
REQ-022 SHALL require x_addr/x_data stable only at the accepting edge; a_valid/b_valid MAY drop without acceptance.

Reset
REQ-023 SHALL, while rst=1, clear both full flags and drive wen=0, waddr=0, wdata=0, conflict_cnt=0, priority pointer = B.
REQ-024 SHALL discard buffered, ungranted writes when reset asserts mid-operation; no wen SHALL follow reset release until a new acceptance.
REQ-025 SHALL drive a_ready=b_ready=1 from the first cycle after reset deasserts.

Configuration
REQ-026 SHALL support macro WB_RR_ARB_EN. When it is defined, round-robin arbitration SHALL apply: when both buffers are full, the requester not granted most recently wins, the pointer updates only on contested grants, and B wins first after reset.
REQ-027 When WB_RR_ARB_EN is undefined, fixed priority SHALL apply: B (load) always wins a contest, and the pointer logic SHALL be absent.

Verification
REQ-028 SHALL cover single write: reset, then a_valid, a_addr=5, a_data=32'hDEAD_BEEF for one cycle -> wen=1, waddr=5, wdata=32'hDEAD_BEEF exactly one cycle later, then wen=0.
REQ-029 SHALL cover x0 drop: b_valid, b_addr=0, b_data=32'h1234 -> b accepted, wen stays 0 for all cycles.
REQ-030 SHALL cover a contest: a (addr 3, 32'hA) and b (addr 4, 32'hB) valid in the same cycle. Fixed priority -> write 4 then 3 on consecutive cycles, a_ready=0 for one cycle, conflict_cnt=1. Round-robin, both held valid with new data each cycle -> writes alternate B,A,B,A.
REQ-031 SHALL cover streaming: a_valid held for 10 cycles, addr 1..10 -> 10 consecutive wen cycles, a_ready never low.
REQ-032 SHALL cover mid-operation reset: both buffers full, then rst pulsed -> wen never asserts for either entry, and conflict_cnt=0.
REQ-033 SHALL cover saturation: both requesters held valid for 70000 cycles -> conflict_cnt stops at 16'hFFFF.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus for regfile_wb_arbiter: two requester handshakes (ALU = a, load = b)
// plus the register-file write port and the contest counter.
interface regfile_wb_arbiter_if #(
    parameter int N = 32,
    parameter int W = 32
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_addr;
    logic [W-1:0]  a_data;

    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic [W-1:0]  b_data;

    logic          wen;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [15:0]   conflict_cnt;

    // Requester side: drives the writeback requests, observes ready and the write port.
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, wen, waddr, wdata, conflict_cnt
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, wen, waddr, wdata, conflict_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester register-file writeback arbiter with one-entry buffers per requester.
// Macro WB_RR_ARB_EN selects round-robin contests; default is fixed priority to B (load).
module regfile_wb_arbiter #(
    parameter int N = 32,
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;

    logic          full_a, full_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [W-1:0]  data_a, data_b;
    logic          grant_a, grant_b;
    logic          accept_a, accept_b;

    logic          wen_q;
    logic [AW-1:0] waddr_q;
    logic [W-1:0]  wdata_q;
    logic [15:0]   conflict_q;

`ifdef WB_RR_ARB_EN
    // Set when B should win the next contest; flips only on contested grants.
    logic prio_b;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
`ifdef WB_RR_ARB_EN
        if (full_b && (!full_a || prio_b))
            grant_b = 1'b1;
        else if (full_a)
            grant_a = 1'b1;
`else
        if (full_b)
            grant_b = 1'b1;
        else if (full_a)
            grant_a = 1'b1;
`endif
    end

    // A buffer being drained this cycle can take a new entry at the same edge.
    assign bus.a_ready = !full_a || grant_a;
    assign bus.b_ready = !full_b || grant_b;
    assign accept_a    = bus.a_valid && bus.a_ready;
    assign accept_b    = bus.b_valid && bus.b_ready;

    // NOTE: payload registers carry no reset; the full flags alone say whether they mean anything.
    always_ff @(posedge clk) begin
        if (accept_a) begin
            addr_a <= bus.a_addr;
            data_a <= bus.a_data;
        end
        if (accept_b) begin
            addr_b <= bus.b_addr;
            data_b <= bus.b_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_a     <= 1'b0;
            full_b     <= 1'b0;
            wen_q      <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            conflict_q <= '0;
`ifdef WB_RR_ARB_EN
            prio_b     <= 1'b1;
`endif
        end else begin
            wen_q <= 1'b0;
            // Writes to x0 still move through the port but never raise wen.
            if (grant_a) begin
                wen_q   <= (addr_a != '0);
                waddr_q <= addr_a;
                wdata_q <= data_a;
            end else if (grant_b) begin
                wen_q   <= (addr_b != '0);
                waddr_q <= addr_b;
                wdata_q <= data_b;
            end

            if (accept_a)
                full_a <= 1'b1;
            else if (grant_a)
                full_a <= 1'b0;

            if (accept_b)
                full_b <= 1'b1;
            else if (grant_b)
                full_b <= 1'b0;

            if (full_a && full_b && (conflict_q != 16'hFFFF))
                conflict_q <= conflict_q + 16'd1;

`ifdef WB_RR_ARB_EN
            if (full_a && full_b)
                prio_b <= grant_a;
`endif
        end
    end

    assign bus.wen          = wen_q;
    assign bus.waddr        = waddr_q;
    assign bus.wdata        = wdata_q;
    assign bus.conflict_cnt = conflict_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter: a vector table for the basic
// write/drop/contest flow, plus hand-written streaming, reset, alternation and saturation runs.
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    regfile_wb_arbiter_if #(.N(32), .W(32)) bus ();

    regfile_wb_arbiter #(.N(32), .W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        ewen;
        logic [4:0]  ewaddr;
        logic [31:0] ewdata;
        logic        ear;
        logic        ebr;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        bus.a_valid = av;
        bus.a_addr  = aa;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_addr  = ba;
        bus.b_data  = bd;
    endtask

    task automatic do_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        //            av  aa  ad            bv  ba  bd        wen waddr wdata         ar  br
        vecs[0]  = '{1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,         1'b1, 1'b1};
        vecs[1]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,         1'b1, 1'b1};
        vecs[2]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 32'h1234, 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h1234,      1'b1, 1'b1};
        vecs[6]  = '{1'b1, 5'd3, 32'hA,         1'b1, 5'd4, 32'hB,    1'b0, 5'd0, 32'h1234,      1'b1, 1'b1};
        vecs[7]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h1234,      1'b0, 1'b1};
        vecs[8]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b1, 5'd4, 32'hB,         1'b1, 1'b1};
        vecs[9]  = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'hA,         1'b1, 1'b1};
        vecs[10] = '{1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,    1'b0, 5'd3, 32'hA,         1'b1, 1'b1};

        // Reset state, sampled while rst is still high.
        step();
        step();
        check("rst_wen", {31'd0, bus.wen}, 32'd0);
        check("rst_waddr", {27'd0, bus.waddr}, 32'd0);
        check("rst_wdata", bus.wdata, 32'd0);
        check("rst_conflict", {16'd0, bus.conflict_cnt}, 32'd0);
        rst = 1'b0;
        check("rel_a_ready", {31'd0, bus.a_ready}, 32'd1);
        check("rel_b_ready", {31'd0, bus.b_ready}, 32'd1);

        // Single write, x0 drop, fixed-order contest.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
            check($sformatf("vec%0d_wen", i), {31'd0, bus.wen}, {31'd0, vecs[i].ewen});
            check($sformatf("vec%0d_waddr", i), {27'd0, bus.waddr}, {27'd0, vecs[i].ewaddr});
            check($sformatf("vec%0d_wdata", i), bus.wdata, vecs[i].ewdata);
            check($sformatf("vec%0d_a_ready", i), {31'd0, bus.a_ready}, {31'd0, vecs[i].ear});
            check($sformatf("vec%0d_b_ready", i), {31'd0, bus.b_ready}, {31'd0, vecs[i].ebr});
            step();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("contest_conflict", {16'd0, bus.conflict_cnt}, 32'd1);

        // Streaming: ten back-to-back ALU writes, one write per cycle.
        do_reset();
        for (int j = 0; j <= 12; j++) begin
            if (j < 10)
                drive(1'b1, 5'(j + 1), 32'h100 + 32'(j + 1), 1'b0, 5'd0, 32'd0);
            else
                drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
            check($sformatf("stream%0d_a_ready", j), {31'd0, bus.a_ready}, 32'd1);
            if (j >= 2 && j <= 11) begin
                check($sformatf("stream%0d_wen", j), {31'd0, bus.wen}, 32'd1);
                check($sformatf("stream%0d_waddr", j), {27'd0, bus.waddr}, 32'(j - 1));
                check($sformatf("stream%0d_wdata", j), bus.wdata, 32'h100 + 32'(j - 1));
            end else begin
                check($sformatf("stream%0d_wen", j), {31'd0, bus.wen}, 32'd0);
            end
            step();
        end

        // Mid-operation reset with both buffers holding entries.
        do_reset();
        drive(1'b1, 5'd7, 32'h7777, 1'b1, 5'd8, 32'h8888);
        step();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_wen_async", {31'd0, bus.wen}, 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            check($sformatf("midrst%0d_wen", j), {31'd0, bus.wen}, 32'd0);
            check($sformatf("midrst%0d_conflict", j), {16'd0, bus.conflict_cnt}, 32'd0);
            step();
        end

        // Both requesters held valid with fresh data each cycle.
        do_reset();
        for (int j = 0; j < 8; j++) begin
            drive(1'b1, 5'd1, 32'hA000 + 32'(j), 1'b1, 5'd2, 32'hB000 + 32'(j));
            if (j >= 2) begin
                check($sformatf("alt%0d_wen", j), {31'd0, bus.wen}, 32'd1);
`ifdef WB_RR_ARB_EN
                check($sformatf("alt%0d_waddr", j), {27'd0, bus.waddr}, (j % 2 == 0) ? 32'd2 : 32'd1);
`else
                check($sformatf("alt%0d_waddr", j), {27'd0, bus.waddr}, 32'd2);
                check($sformatf("alt%0d_wdata", j), bus.wdata, 32'hB000 + 32'(j - 2));
`endif
            end
            step();
        end

        // Saturation of the contest counter.
        do_reset();
        drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        for (int j = 0; j < 70000; j++)
            @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("sat_conflict", {16'd0, bus.conflict_cnt}, 32'h0000_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
